frame_copy_engine: RTL and testbench
====================================

FRAME_COPY_ENGINE -- requirements
Module: frame_copy_engine

Interface
REQ-001 Parameter SCREEN_W, default 160, screen width in pixels.
REQ-002 Parameter SCREEN_H, default 120, screen height in pixels.
REQ-003 Parameter SPRITE_DIM, default 8, sprite/tile edge in pixels (power of two).
REQ-004 The module SHALL have the following ports, one per line: name, direction, width, meaning.
  - clock  in  1  system clock (50 MHz); one clock, all logic on rising edge.
  - reset  in  1  synchronous, active-high.
  - copy_enable  in  1  request level from game control; held high for the whole copy.
  - draw_stage  in  1  1 = full-screen copy; 0 = sprite copy.
  - memory_select  in  2  source ROM: 0 title, 1 stage, 2 win, 3 sprite.
  - black  in  1  force written colour to 0.
  - origin_x  in  8  sprite top-left x.
  - origin_y  in  7  sprite top-left y.
  - sprite_base  in  15  sprite ROM base address.
  - mem_sel  out  2  registered ROM select.
  - mem_addr  out  15  ROM read address.
  - mem_data  in  3  ROM colour; valid one cycle after mem_addr.
  - buf_x  out  8  buffer write x.
  - buf_y  out  7  buffer write y.
  - buf_colour  out  3  buffer write colour.
  - buf_write  out  1  buffer write strobe.
  - finished  out  1  one-cycle completion pulse.

Function
REQ-005 States: IDLE, RUN, DRAIN, DONE.
REQ-006 IDLE -> RUN when copy_enable=1. On that edge, capture draw_stage, memory_select, black, origin and sprite_base; clear the column and row counters.
REQ-007 RUN issues one address per cycle in raster order (column fastest). The region is SCREEN_W x SCREEN_H when draw_stage=1, otherwise SPRITE_DIM x SPRITE_DIM.
REQ-008 mem_addr SHALL be row*SCREEN_W+col in stage mode and sprite_base+row*SPRITE_DIM+col in sprite mode. Arithmetic is 15-bit and wraps modulo 2^15.
REQ-009 The write pipeline lags by exactly one cycle. buf_x, buf_y and buf_write correspond to the address issued in the previous cycle, and buf_colour equals mem_data.
REQ-010 Sprite mode: buf_x=origin_x+col and buf_y=origin_y+row. Any pixel with buf_x>=SCREEN_W or buf_y>=SCREEN_H SHALL have buf_write=0 (clipped, no wrap).
REQ-011 When the captured black=1, buf_colour SHALL be 0 for every written pixel.
REQ-012 RUN -> DRAIN after the last address is issued. DRAIN performs the final write. DRAIN -> DONE.
REQ-013 DONE asserts finished=1 for exactly one cycle and then returns to IDLE. finished is 0 in all other states.
REQ-014 A new request is accepted only from IDLE, so back-to-back requests cost one idle cycle after DONE.
REQ-015 copy_enable=0 in RUN or DRAIN SHALL abort to IDLE on the next edge: no further writes and no finished pulse.
REQ-016 Latency from the accepting edge to the finished pulse is N+2 cycles: 19202 in stage mode, 66 in sprite mode.
REQ-017 memory_select and draw_stage changes during a copy SHALL be ignored.

Reset
REQ-018 On reset=1 at a clock edge, the state becomes IDLE and the counters clear. This applies mid-copy as well.
REQ-019 Reset values: mem_sel=0, mem_addr=0, buf_x=0, buf_y=0, buf_colour=0, buf_write=0, finished=0.

Configuration
REQ-020 Macro FRAME_COPY_TRANSPARENCY_EN.
  - Defined: in sprite mode with black=0, pixels with mem_data=0 SHALL have buf_write=0.
  - Undefined: every in-bounds pixel is written regardless of colour.
  - Stage mode always writes every pixel.

Structure
REQ-021 Shared package bomberman_pkg SHALL hold:
  - the state encoding;
  - the memory_select constants MEM_TITLE, MEM_STAGE, MEM_WIN, MEM_SPRITE;
  - SCREEN_W, SCREEN_H and SPRITE_DIM defaults.
REQ-022 One sub-module, raster_counter, SHALL provide the col/row counter with last-pixel flag, parameterised by width and height.

Verification
REQ-023 Sprite copy: origin (16,8), base 64, ROM value = address[2:0].
  - Expect 64 writes at x 16..23, y 8..15, with colour equal to the address issued one cycle earlier.
  - Expect finished exactly 66 cycles after acceptance.
REQ-024 Stage copy with memory_select=1.
  - Expect 19200 writes and last write at (159,119).
  - Expect mem_addr 19199 on the last issue and finished after 19202 cycles.
REQ-025 Clipping: sprite at origin (156,116). Expect 16 writes only, at x 156..159, y 116..119.
REQ-026 black=1 sprite copy with a nonzero ROM. Expect all 64 writes with colour 0.
  - With FRAME_COPY_TRANSPARENCY_EN defined and a ROM of zeros at black=0, expect 0 writes and finished still pulsed.
REQ-027 Abort and reset.
  - Drop copy_enable at pixel 10: no finished, IDLE next cycle.
  - Assert reset at pixel 30 of a stage copy: all outputs at reset values next cycle, and a new request is accepted the following cycle.

Source files
------------

// File: rtl/bomberman_pkg.sv
// bomberman_pkg: shared state encoding, ROM select codes and screen geometry defaults.
package bomberman_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;
    localparam logic [1:0] MEM_TITLE = 2'd0;
    localparam logic [1:0] MEM_STAGE = 2'd1;
    localparam logic [1:0] MEM_WIN = 2'd2;
    localparam logic [1:0] MEM_SPRITE = 2'd3;
    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;
    localparam int DEF_SPRITE_DIM = 8;
endpackage

// File: rtl/frame_copy_engine_if.sv
// frame_copy_engine_if: request, ROM read and frame-buffer write signals of the copy engine.
interface frame_copy_engine_if;
    logic copy_enable;
    logic draw_stage;
    logic [1:0] memory_select;
    logic black;
    logic [7:0] origin_x;
    logic [6:0] origin_y;
    logic [14:0] sprite_base;
    logic [1:0] mem_sel;
    logic [14:0] mem_addr;
    logic [2:0] mem_data;
    logic [7:0] buf_x;
    logic [6:0] buf_y;
    logic [2:0] buf_colour;
    logic buf_write;
    logic finished;
    modport slave (
        input copy_enable, draw_stage, memory_select, black, origin_x, origin_y, sprite_base, mem_data,
        output mem_sel, mem_addr, buf_x, buf_y, buf_colour, buf_write, finished
    );
    modport master (
        output copy_enable, draw_stage, memory_select, black, origin_x, origin_y, sprite_base, mem_data,
        input mem_sel, mem_addr, buf_x, buf_y, buf_colour, buf_write, finished
    );
endinterface

// File: rtl/raster_counter.sv
// raster_counter: column-fastest W x H scan counter with a flag marking the final pixel.
module raster_counter #(
    parameter int W = 8,
    parameter int H = 8,
    parameter int CW = 8,
    parameter int RW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] col_o,
    output logic [RW-1:0] row_o,
    output logic          last_o
);
    localparam logic [CW-1:0] CMAX = CW'(W - 1);
    localparam logic [RW-1:0] RMAX = RW'(H - 1);
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic col_end;
    always_comb begin
        col_end = col_q == CMAX;
        last_o = col_end && row_q == RMAX;
        col_d = clr_i ? '0 : en_i ? (col_end ? '0 : col_q + 1'b1) : col_q;
        row_d = clr_i ? '0 : (en_i && col_end) ? (last_o ? '0 : row_q + 1'b1) : row_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
    assign col_o = col_q;
    assign row_o = row_q;
endmodule

// File: rtl/frame_copy_engine.sv
// frame_copy_engine: copies a full screen or a clipped sprite from ROM into the frame buffer.
// Define FRAME_COPY_TRANSPARENCY_EN to skip colour-0 sprite pixels.
module frame_copy_engine
    import bomberman_pkg::*;
#(
    parameter int SCREEN_W = DEF_SCREEN_W,
    parameter int SCREEN_H = DEF_SCREEN_H,
    parameter int SPRITE_DIM = DEF_SPRITE_DIM
) (
    input logic clock,
    input logic reset,
    frame_copy_engine_if.slave bus
);
    state_t state_q, state_d;
    logic stage_q, black_q, issued_q, av_q, wv_q;
    logic [1:0] sel_q;
    logic [7:0] ox_q, ax_q, bx_q;
    logic [6:0] oy_q, ay_q, by_q;
    logic [14:0] base_q, addr_q, addr_d;
    logic [7:0] scol, pcol, col;
    logic [6:0] srow, prow, row;
    logic slast, plast, last;
    logic accept, live, issue, inb, opaque;
    logic [8:0] xs;
    logic [7:0] ys;

    always_comb begin
        accept = state_q == ST_IDLE && bus.copy_enable;
        live = (state_q == ST_RUN || state_q == ST_DRAIN) && bus.copy_enable;
        issue = live && state_q == ST_RUN && !issued_q;
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = bus.copy_enable ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = !bus.copy_enable ? ST_IDLE : issued_q ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = bus.copy_enable ? ST_DONE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    raster_counter #(.W(SCREEN_W), .H(SCREEN_H), .CW(8), .RW(7)) u_stage_cnt (
        .clk(clock), .rst(reset), .clr_i(accept), .en_i(issue && stage_q),
        .col_o(scol), .row_o(srow), .last_o(slast)
    );

    raster_counter #(.W(SPRITE_DIM), .H(SPRITE_DIM), .CW(8), .RW(7)) u_sprite_cnt (
        .clk(clock), .rst(reset), .clr_i(accept), .en_i(issue && !stage_q),
        .col_o(pcol), .row_o(prow), .last_o(plast)
    );

    // Sums are one bit wider than the buffer coordinates so off-screen pixels clip instead of wrapping
    always_comb begin
        col = stage_q ? scol : pcol;
        row = stage_q ? srow : prow;
        last = stage_q ? slast : plast;
        addr_d = stage_q ? 15'(row) * 15'(SCREEN_W) + 15'(col)
                         : base_q + 15'(row) * 15'(SPRITE_DIM) + 15'(col);
        xs = stage_q ? {1'b0, col} : {1'b0, ox_q} + {1'b0, col};
        ys = stage_q ? {1'b0, row} : {1'b0, oy_q} + {1'b0, row};
        inb = xs < 9'(SCREEN_W) && ys < 8'(SCREEN_H);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            stage_q <= 1'b0;
            black_q <= 1'b0;
            sel_q <= 2'd0;
            ox_q <= 8'd0;
            oy_q <= 7'd0;
            base_q <= 15'd0;
            issued_q <= 1'b0;
            addr_q <= 15'd0;
            ax_q <= 8'd0;
            ay_q <= 7'd0;
            av_q <= 1'b0;
            bx_q <= 8'd0;
            by_q <= 7'd0;
            wv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                stage_q <= bus.draw_stage;
                sel_q <= bus.memory_select;
                black_q <= bus.black;
                ox_q <= bus.origin_x;
                oy_q <= bus.origin_y;
                base_q <= bus.sprite_base;
                issued_q <= 1'b0;
            end
            if (issue) begin
                addr_q <= addr_d;
                ax_q <= xs[7:0];
                ay_q <= ys[6:0];
                issued_q <= last;
            end
            av_q <= issue && inb;
            wv_q <= av_q && live;
            if (av_q && live) begin
                bx_q <= ax_q;
                by_q <= ay_q;
            end
        end
    end

`ifdef FRAME_COPY_TRANSPARENCY_EN
    assign opaque = stage_q || black_q || bus.mem_data != 3'd0;
`else
    assign opaque = 1'b1;
`endif

    assign bus.mem_sel = sel_q;
    assign bus.mem_addr = addr_q;
    assign bus.buf_x = bx_q;
    assign bus.buf_y = by_q;
    assign bus.buf_colour = (wv_q && !black_q) ? bus.mem_data : 3'd0;
    assign bus.buf_write = wv_q && opaque;
    assign bus.finished = state_q == ST_DONE;
endmodule

// File: tb/tb_frame_copy_engine.sv
// tb_frame_copy_engine: scoreboard bench for sprite, stage, clip, black, abort and reset copies.
module tb_frame_copy_engine;
    import bomberman_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } px_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    frame_copy_engine_if bus();
    frame_copy_engine dut (.clock(clock), .reset(reset), .bus(bus));

    px_t exp_q[$];
    px_t e;
    int passed = 0;
    int total = 0;
    int rom_mode = 0;
    int writes = 0;
    int fin_cnt = 0;
    logic [7:0] lx;
    logic [6:0] ly;

    function automatic logic [2:0] rom_val(input logic [14:0] a);
        return rom_mode == 1 ? 3'd0 : rom_mode == 2 ? (a[2:0] | 3'd1) : a[2:0];
    endfunction

    // ROM model with one cycle of read latency
    always @(posedge clock) bus.mem_data <= rom_val(bus.mem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    always @(negedge clock) begin
        if (!reset && bus.buf_write) begin
            writes++;
            lx = bus.buf_x;
            ly = bus.buf_y;
            chk("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("write_pixel", {bus.buf_x, bus.buf_y, bus.buf_colour}, e);
            end
        end
        if (!reset && bus.finished) fin_cnt++;
    end

    task automatic push_exp(input logic stage, input logic blk, input int ox, input int oy, input int base);
        int w, h, x, y;
        logic [14:0] a;
        logic [2:0] v;
        logic skip;
        w = stage ? 160 : 8;
        h = stage ? 120 : 8;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                x = stage ? c : ox + c;
                y = stage ? r : oy + r;
                a = stage ? 15'(r * 160 + c) : 15'(base + r * 8 + c);
                v = rom_val(a);
                skip = 1'b0;
`ifdef FRAME_COPY_TRANSPARENCY_EN
                skip = !stage && !blk && v == 3'd0;
`endif
                if (x < 160 && y < 120 && !skip) exp_q.push_back({8'(x), 7'(y), blk ? 3'd0 : v});
            end
    endtask

    task automatic start(input logic stage, input logic [1:0] sel, input logic blk,
                         input logic [7:0] ox, input logic [6:0] oy, input logic [14:0] base);
        @(negedge clock);
        bus.draw_stage = stage;
        bus.memory_select = sel;
        bus.black = blk;
        bus.origin_x = ox;
        bus.origin_y = oy;
        bus.sprite_base = base;
        bus.copy_enable = 1'b1;
        @(posedge clock);
    endtask

    task automatic wait_fin(input int budget, output int k);
        for (k = 0; k < budget; k++) begin
            @(negedge clock);
            if (bus.finished) break;
        end
    endtask

    task automatic copy(input string tag, input logic stage, input logic [1:0] sel, input logic blk,
                        input logic [7:0] ox, input logic [6:0] oy, input logic [14:0] base,
                        input int exp_lat, input int exp_wr, input logic [7:0] ex, input logic [6:0] ey,
                        input logic [14:0] ea);
        int k, f0;
        push_exp(stage, blk, ox, oy, base);
        writes = 0;
        f0 = fin_cnt;
        start(stage, sel, blk, ox, oy, base);
        #1;
        bus.draw_stage = !stage;
        bus.memory_select = ~sel;
        wait_fin(exp_lat + 50, k);
        chk({tag, "_latency"}, k, exp_lat);
        chk({tag, "_writes"}, writes, exp_wr);
        if (exp_wr > 0) chk({tag, "_last_xy"}, {lx, ly}, {ex, ey});
        chk({tag, "_last_addr"}, bus.mem_addr, ea);
        chk({tag, "_mem_sel"}, bus.mem_sel, sel);
        bus.copy_enable = 1'b0;
        @(negedge clock);
        chk({tag, "_pulse_end"}, {bus.finished, dut.state_q}, {1'b0, ST_IDLE});
        chk({tag, "_queue_empty"}, exp_q.size(), 0);
        chk({tag, "_fin_count"}, fin_cnt - f0, 1);
    endtask

    initial begin
        int k, w0, f0;
        reset = 1'b1;
        bus.copy_enable = 1'b0;
        bus.draw_stage = 1'b0;
        bus.memory_select = 2'd0;
        bus.black = 1'b0;
        bus.origin_x = 8'd0;
        bus.origin_y = 7'd0;
        bus.sprite_base = 15'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", {bus.mem_sel, bus.mem_addr, bus.buf_x, bus.buf_y, bus.buf_colour,
                              bus.buf_write, bus.finished}, 0);
        reset = 1'b0;

        rom_mode = 0;
        copy("sprite", 1'b0, MEM_SPRITE, 1'b0, 8'd16, 7'd8, 15'd64, 66, 64, 8'd23, 7'd15, 15'd127);
        copy("stage", 1'b1, MEM_STAGE, 1'b0, 8'd0, 7'd0, 15'd0, 19202, 19200, 8'd159, 7'd119, 15'd19199);
        copy("clip", 1'b0, MEM_SPRITE, 1'b0, 8'd156, 7'd116, 15'd0, 66, 16, 8'd159, 7'd119, 15'd63);
        rom_mode = 2;
        copy("black", 1'b0, MEM_SPRITE, 1'b1, 8'd30, 7'd20, 15'd200, 66, 64, 8'd37, 7'd27, 15'd263);
        rom_mode = 1;
`ifdef FRAME_COPY_TRANSPARENCY_EN
        copy("zero_rom", 1'b0, MEM_SPRITE, 1'b0, 8'd40, 7'd40, 15'd0, 66, 0, 8'd47, 7'd47, 15'd63);
`else
        copy("zero_rom", 1'b0, MEM_SPRITE, 1'b0, 8'd40, 7'd40, 15'd0, 66, 64, 8'd47, 7'd47, 15'd63);
`endif

        rom_mode = 0;
        push_exp(1'b0, 1'b0, 16, 8, 64);
        writes = 0;
        start(1'b0, MEM_SPRITE, 1'b0, 8'd16, 7'd8, 15'd64);
        repeat (10) @(negedge clock);
        bus.copy_enable = 1'b0;
        @(negedge clock);
        chk("abort_idle", {bus.buf_write, dut.state_q}, {1'b0, ST_IDLE});
        w0 = writes;
        f0 = fin_cnt;
        repeat (80) @(negedge clock);
        chk("abort_no_writes", writes, w0);
        chk("abort_no_finish", fin_cnt, f0);
        exp_q.delete();

        push_exp(1'b1, 1'b0, 0, 0, 0);
        start(1'b1, MEM_STAGE, 1'b0, 8'd0, 7'd0, 15'd0);
        repeat (30) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("midcopy_reset", {bus.mem_sel, bus.mem_addr, bus.buf_x, bus.buf_y, bus.buf_colour,
                              bus.buf_write, bus.finished}, 0);
        exp_q.delete();
        bus.draw_stage = 1'b0;
        bus.memory_select = MEM_SPRITE;
        bus.origin_x = 8'd16;
        bus.origin_y = 7'd8;
        bus.sprite_base = 15'd64;
        push_exp(1'b0, 1'b0, 16, 8, 64);
        writes = 0;
        reset = 1'b0;
        @(negedge clock);
        chk("reset_accept", dut.state_q, ST_RUN);
        wait_fin(120, k);
        chk("reset_sprite_latency", k + 1, 66);
        chk("reset_sprite_writes", writes, 64);
        bus.copy_enable = 1'b0;
        @(negedge clock);
        chk("reset_sprite_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
